// File: rtl/trigger_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture_pkg
// Description : Shared state encoding, trigger-select constants and channel
//               helper for the oscilloscope trigger/capture stage.
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_capture_pkg;

    localparam int C_STATE_W = 3;
    localparam int C_CHAN_W  = 16;

    localparam logic [C_STATE_W-1:0] C_ST_IDLE     = 3'd0;
    localparam logic [C_STATE_W-1:0] C_ST_PRETRIG  = 3'd1;
    localparam logic [C_STATE_W-1:0] C_ST_ARMED    = 3'd2;
    localparam logic [C_STATE_W-1:0] C_ST_POSTTRIG = 3'd3;
    localparam logic [C_STATE_W-1:0] C_ST_READOUT  = 3'd4;

    localparam logic C_CH_A = 1'b0;
    localparam logic C_CH_B = 1'b1;

    localparam logic C_EDGE_FALLING = 1'b0;
    localparam logic C_EDGE_RISING  = 1'b1;

    // Channel A occupies the upper half of the sample word, channel B the lower.
    function automatic logic [C_CHAN_W-1:0] f_chan_select(
        input logic [2*C_CHAN_W-1:0] sample,
        input logic                  ch
    );
        f_chan_select = (ch == C_CH_B) ? sample[C_CHAN_W-1:0]
                                       : sample[2*C_CHAN_W-1:C_CHAN_W];
    endfunction

endpackage : trigger_capture_pkg
`default_nettype wire

// File: rtl/trigger_capture_sample_ram.sv
`default_nettype none
// ============================================================================
// Module      : sample_ram
// Description : Simple dual-port sample buffer, one write port and one
//               registered read port (1-cycle latency), BRAM-inferable.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // No reset on the array or read register so the tools map this to block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule : sample_ram
`default_nettype wire

// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture
// Description : Pre-trigger circular capture, level-crossing trigger and
//               oldest-first record readout over a valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture
    import trigger_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic                  trig_channel,
    input  logic                  trig_rising,
    input  logic [15:0]           trig_level,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH_W  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   C_LAST_IDX = C_DEPTH_W - C_CNT_ONE;
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [C_STATE_W-1:0]  r_state;
    logic [C_STATE_W-1:0]  w_state_nxt;

    logic                  r_trig_ch;
    logic                  r_trig_rising;
    logic [C_CHAN_W-1:0]   r_trig_level;
    logic [ADDR_WIDTH-1:0] r_pretrig_len;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [C_CHAN_W-1:0]   r_prev;
    logic                  r_prev_valid;
    logic                  r_force_pend;
    logic                  r_triggered;

    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH:0]   r_rd_issued;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [1:0]            r_occ;
    logic [DATA_WIDTH-1:0] r_head_data;
    logic                  r_head_last;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  r_skid_last;
    logic                  r_done;

    logic                  w_arm_ok;
    logic                  w_write;
    logic [C_CHAN_W-1:0]   w_cur;
    logic                  w_rise;
    logic                  w_fall;
    logic                  w_cross;
    logic                  w_trig_hit;
    logic [ADDR_WIDTH:0]   w_post_total;
    logic [ADDR_WIDTH:0]   w_cnt_inc;
    logic                  w_m_valid;
    logic                  w_pop;
    logic [2:0]            w_fill;
    logic                  w_issue;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // ------------------------------------------------------------------------
    // Trigger comparator and write qualification
    // ------------------------------------------------------------------------
    assign w_arm_ok = (r_state == C_ST_IDLE) && arm;
    assign w_write  = data_valid && ((r_state == C_ST_PRETRIG) ||
                                     (r_state == C_ST_ARMED)   ||
                                     (r_state == C_ST_POSTTRIG));

    assign w_cur   = f_chan_select(data_in, r_trig_ch);
    assign w_rise  = (r_prev <  r_trig_level) && (w_cur >= r_trig_level);
    assign w_fall  = (r_prev >= r_trig_level) && (w_cur <  r_trig_level);
    assign w_cross = r_prev_valid &&
                     ((r_trig_rising == C_EDGE_RISING) ? w_rise : w_fall);

    // A pending force makes the next written sample the trigger sample.
    assign w_trig_hit = (r_state == C_ST_ARMED) && data_valid &&
                        (w_cross || r_force_pend || force_trig);

    assign w_post_total = C_DEPTH_W - {1'b0, r_pretrig_len};
    assign w_cnt_inc    = r_cnt + C_CNT_ONE;

    // ------------------------------------------------------------------------
    // Readout flow control: head + skid entries plus one read in flight
    // ------------------------------------------------------------------------
    assign w_m_valid = (r_occ != 2'd0);
    assign w_pop     = w_m_valid && m_ready;
    assign w_fill    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = (r_state == C_ST_READOUT) && (r_rd_issued != C_DEPTH_W) &&
                       (w_fill < 3'd2);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (arm) begin
                    w_state_nxt = (pretrig_len == '0) ? C_ST_ARMED : C_ST_PRETRIG;
                end
            end
            C_ST_PRETRIG: begin
                if (w_write && (w_cnt_inc == {1'b0, r_pretrig_len})) begin
                    w_state_nxt = C_ST_ARMED;
                end
            end
            C_ST_ARMED: begin
                if (w_trig_hit) begin
                    // With DEPTH-1 pre-trigger samples the trigger sample closes the record.
                    w_state_nxt = (w_post_total == C_CNT_ONE) ? C_ST_READOUT
                                                              : C_ST_POSTTRIG;
                end
            end
            C_ST_POSTTRIG: begin
                if (w_write && (w_cnt_inc == w_post_total)) begin
                    w_state_nxt = C_ST_READOUT;
                end
            end
            C_ST_READOUT: begin
                if (w_pop && r_head_last) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            default: w_state_nxt = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Capture-side pointers, counters and latched configuration
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig_ch     <= C_CH_A;
            r_trig_rising <= C_EDGE_FALLING;
            r_trig_level  <= '0;
            r_pretrig_len <= '0;
            r_wr_ptr      <= '0;
            r_cnt         <= '0;
            r_prev        <= '0;
            r_prev_valid  <= 1'b0;
            r_force_pend  <= 1'b0;
            r_triggered   <= 1'b0;
        end else begin
            if (w_arm_ok) begin
                r_trig_ch     <= trig_channel;
                r_trig_rising <= trig_rising;
                r_trig_level  <= trig_level;
                r_pretrig_len <= pretrig_len;
                r_wr_ptr      <= '0;
                r_cnt         <= '0;
                r_prev_valid  <= 1'b0;
                r_force_pend  <= 1'b0;
                r_triggered   <= 1'b0;
            end

            if (w_write) begin
                r_wr_ptr     <= r_wr_ptr + C_PTR_ONE;
                r_prev       <= w_cur;
                r_prev_valid <= 1'b1;
            end

            if (w_trig_hit) begin
                r_cnt        <= C_CNT_ONE;
                r_triggered  <= 1'b1;
                r_force_pend <= 1'b0;
            end else if (w_write && ((r_state == C_ST_PRETRIG) ||
                                     (r_state == C_ST_POSTTRIG))) begin
                r_cnt <= w_cnt_inc;
            end else if ((r_state == C_ST_ARMED) && force_trig) begin
                r_force_pend <= 1'b1;
            end

            if (w_pop && r_head_last) begin
                r_triggered <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Readout: address generation and two-entry output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_addr       <= '0;
            r_rd_issued     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_occ           <= 2'd0;
            r_head_data     <= '0;
            r_head_last     <= 1'b0;
            r_skid_data     <= '0;
            r_skid_last     <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            // The trigger sample sits at r_wr_ptr; the record starts pretrig_len earlier.
            if (w_trig_hit) begin
                r_rd_addr   <= r_wr_ptr - r_pretrig_len;
                r_rd_issued <= '0;
            end else if (w_issue) begin
                r_rd_addr   <= r_rd_addr + C_PTR_ONE;
                r_rd_issued <= r_rd_issued + C_CNT_ONE;
            end

            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_last <= (r_rd_issued == C_LAST_IDX);
            end

            case ({r_inflight, w_pop})
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_head_data <= r_skid_data;
                        r_head_last <= r_skid_last;
                        r_skid_data <= w_rd_data;
                        r_skid_last <= r_inflight_last;
                    end else begin
                        r_head_data <= w_rd_data;
                        r_head_last <= r_inflight_last;
                    end
                end
                2'b01: begin
                    if (r_occ == 2'd2) begin
                        r_head_data <= r_skid_data;
                        r_head_last <= r_skid_last;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head_data <= w_rd_data;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_skid_data <= w_rd_data;
                        r_skid_last <= r_inflight_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                default: ;
            endcase

            r_done <= w_pop && r_head_last;
        end
    end

    sample_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sample_ram (
        .clk       (clk),
        .i_wr_en   (w_write),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_issue),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign m_data    = r_head_data;
    assign m_valid   = w_m_valid;
    assign m_last    = w_m_valid && r_head_last;
    assign busy      = (r_state != C_ST_IDLE);
    assign triggered = r_triggered;
    assign done      = r_done;

endmodule : trigger_capture
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_capture
// Description : Directed, table-driven bench for trigger_capture (DEPTH = 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] data_in;
    logic          data_valid;
    logic          arm;
    logic          force_trig;
    logic          trig_channel;
    logic          trig_rising;
    logic [15:0]   trig_level;
    logic [AW-1:0] pretrig_len;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          triggered;
    logic          done;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          id;
        logic        ch;
        logic        rising;
        logic [15:0] level;
        logic [3:0]  pre;
        int          kind;      // 0: ramp on A, 1: B counts down from 60, 2: A const, B = index
        int          force_at;  // force_trig pulsed before this sample index (-1: never)
        bit          stall;
        int          first_k;   // sample index expected at record position 0
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    trigger_capture #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .arm          (arm),
        .force_trig   (force_trig),
        .trig_channel (trig_channel),
        .trig_rising  (trig_rising),
        .trig_level   (trig_level),
        .pretrig_len  (pretrig_len),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .busy         (busy),
        .triggered    (triggered),
        .done         (done)
    );

    function automatic logic [31:0] gen(input int kind, input int k);
        logic [15:0] kk;
        logic [15:0] dn;
        kk = k[15:0];
        dn = 16'd60 - kk;
        case (kind)
            0:       gen = {kk, 16'h0000};
            1:       gen = {16'h1234, dn};
            default: gen = {16'h0200, kk};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_arm(input vec_t v);
        trig_channel = v.ch;
        trig_rising  = v.rising;
        trig_level   = v.level;
        pretrig_len  = v.pre;
        arm          = 1'b1;
        tick();
        arm          = 1'b0;
        // Configuration must be held internally from the arm cycle on.
        trig_channel = ~v.ch;
        trig_rising  = ~v.rising;
        trig_level   = ~v.level;
        pretrig_len  = 4'd9;
    endtask

    // Feeds one sample every 4th cycle until readout starts or stop_k samples are sent.
    task automatic feed(input vec_t v, input int stop_k, output bit saw_valid);
        int k;
        int cyc;
        bit forced;
        k = 0;
        cyc = 0;
        forced = 1'b0;
        saw_valid = 1'b0;
        while (cyc < 4000) begin
            if (m_valid) begin
                saw_valid = 1'b1;
                break;
            end
            if (stop_k >= 0 && k >= stop_k) break;
            data_valid = 1'b0;
            force_trig = 1'b0;
            data_in    = 32'hDEAD_BEEF;
            if (cyc % 4 == 0) begin
                data_valid = 1'b1;
                data_in    = gen(v.kind, k);
                k++;
            end else if (cyc % 4 == 2 && !forced && v.force_at >= 0 && k == v.force_at) begin
                check($sformatf("v%0d triggered before force", v.id), {31'b0, triggered}, 32'd0);
                check($sformatf("v%0d busy before force", v.id), {31'b0, busy}, 32'd1);
                force_trig = 1'b1;
                forced     = 1'b1;
            end
            tick();
            cyc++;
        end
        data_valid = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic read_record(input vec_t v);
        int idx;
        int cyc;
        int done_cnt;
        logic [31:0] exp;
        idx = 0;
        cyc = 0;
        done_cnt = 0;
        while (idx < DEPTH && cyc < 400) begin
            m_ready = v.stall ? (cyc % 3 == 0) : 1'b1;
            if (done) done_cnt++;
            if (m_valid) begin
                exp = gen(v.kind, v.first_k + idx);
                if (idx == 0)
                    check($sformatf("v%0d triggered in readout", v.id), {31'b0, triggered}, 32'd1);
                check($sformatf("v%0d data[%0d]", v.id, idx), m_data, exp);
                check($sformatf("v%0d last[%0d]", v.id, idx), {31'b0, m_last},
                      (idx == DEPTH-1) ? 32'd1 : 32'd0);
                if (m_ready) idx++;
            end else if (!v.stall && idx > 0) begin
                check($sformatf("v%0d bubble at %0d", v.id, idx), {31'b0, m_valid}, 32'd1);
            end
            tick();
            cyc++;
        end
        m_ready = 1'b0;
        check($sformatf("v%0d samples read", v.id), idx, DEPTH);
        check($sformatf("v%0d early done", v.id), done_cnt, 0);
        check($sformatf("v%0d done pulse", v.id), {31'b0, done}, 32'd1);
        check($sformatf("v%0d busy after", v.id), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d triggered after", v.id), {31'b0, triggered}, 32'd0);
        check($sformatf("v%0d m_valid after", v.id), {31'b0, m_valid}, 32'd0);
        tick();
        check($sformatf("v%0d done one cycle", v.id), {31'b0, done}, 32'd0);
    endtask

    task automatic run_capture(input vec_t v);
        bit saw;
        do_arm(v);
        feed(v, -1, saw);
        check($sformatf("v%0d reached readout", v.id), {31'b0, saw}, 32'd1);
        if (saw) read_record(v);
    endtask

    initial begin
        bit saw;
        //           id ch    rise  level     pre kind force stall first
        vecs[0] = '{0, 1'b0, 1'b1, 16'd100,  4'd4, 0, -1, 1'b0, 96};
        vecs[1] = '{1, 1'b0, 1'b1, 16'd1,    4'd4, 0, 10, 1'b0, 6};
        vecs[2] = '{2, 1'b1, 1'b0, 16'd50,   4'd0, 1, -1, 1'b0, 11};
        vecs[3] = '{3, 1'b0, 1'b1, 16'd100,  4'd4, 0, -1, 1'b1, 96};
        vecs[4] = '{4, 1'b0, 1'b1, 16'h0100, 4'd4, 2, 7,  1'b0, 3};

        reset        = 1'b1;
        data_in      = '0;
        data_valid   = 1'b0;
        arm          = 1'b0;
        force_trig   = 1'b0;
        trig_channel = 1'b0;
        trig_rising  = 1'b0;
        trig_level   = '0;
        pretrig_len  = '0;
        m_ready      = 1'b0;
        repeat (3) tick();
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset triggered", {31'b0, triggered}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset m_valid", {31'b0, m_valid}, 32'd0);
        check("reset m_last", {31'b0, m_last}, 32'd0);
        check("reset m_data", m_data, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_capture(vecs[i]);
            repeat (2) tick();
        end

        // Reset in the middle of the post-trigger phase, then a clean re-run.
        do_arm(vecs[0]);
        feed(vecs[0], 105, saw);
        check("mid-post busy", {31'b0, busy}, 32'd1);
        check("mid-post triggered", {31'b0, triggered}, 32'd1);
        reset = 1'b1;
        tick();
        check("post-reset busy", {31'b0, busy}, 32'd0);
        check("post-reset triggered", {31'b0, triggered}, 32'd0);
        check("post-reset m_valid", {31'b0, m_valid}, 32'd0);
        reset = 1'b0;
        tick();
        run_capture(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_trigger_capture
`default_nettype wire
